// File: rtl/data_check_pkg.sv
// Shared definitions for the debug-pattern stream checker: FSM states, lane
// geometry and the saturating counter helper.
package data_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned LANE_W    = 16;
  localparam int unsigned PKT_BEATS = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_check_if.sv
// AXI-Stream beat channel carried into the checker.
interface data_check_if #(
  parameter int unsigned DW = 512
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/data_check_lanes.sv
// Flags a beat whose 16-bit lanes do not all equal the expected counter value.
module data_check_lanes
  import data_check_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic [DW-1:0]     data_i,
  input  logic [LANE_W-1:0] exp_i,
  output logic              mismatch_o
);
  localparam int unsigned LANES = DW / LANE_W;

  always_comb begin
    mismatch_o = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (data_i[i*LANE_W +: LANE_W] != exp_i) mismatch_o = 1'b1;
    end
  end
endmodule

// File: rtl/data_check.sv
// Stream sink that checks the replicated beat-counter debug pattern, counts
// beats/errors, latches the first error and applies programmable backpressure.
module data_check
  import data_check_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        expected_cycles,
  input  logic [3:0]         throttle,
  data_check_if.slave        axis,
  output logic [31:0]        beats_rcvd,
  output logic [31:0]        data_errors,
  output logic [31:0]        last_errors,
  output logic [31:0]        first_err_beat,
  output logic [LANE_W-1:0]  first_err_data,
  output logic               done,
  output logic               pass
);

  state_e              state_q, state_d;
  logic [31:0]         beats_q, beats_d;
  logic [31:0]         derr_q, derr_d;
  logic [31:0]         lerr_q, lerr_d;
  logic [31:0]         fbeat_q, fbeat_d;
  logic [LANE_W-1:0]   fdata_q, fdata_d;
  logic [LANE_W-1:0]   exp_q, exp_d;
  logic [1:0]          pkt_q, pkt_d;
  logic [3:0]          stall_q, stall_d;
  logic [31:0]         ncyc_q, ncyc_d;
  logic [3:0]          thr_q, thr_d;

  logic tready, xfer, data_bad, last_bad;

  data_check_lanes #(.DW(DW)) u_lanes (
    .data_i     (axis.tdata),
    .exp_i      (exp_q),
    .mismatch_o (data_bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beats_q <= '0;
      derr_q  <= '0;
      lerr_q  <= '0;
      fbeat_q <= '0;
      fdata_q <= '0;
      exp_q   <= '0;
      pkt_q   <= '0;
      stall_q <= '0;
      ncyc_q  <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      derr_q  <= derr_d;
      lerr_q  <= lerr_d;
      fbeat_q <= fbeat_d;
      fdata_q <= fdata_d;
      exp_q   <= exp_d;
      pkt_q   <= pkt_d;
      stall_q <= stall_d;
      ncyc_q  <= ncyc_d;
      thr_q   <= thr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    derr_d  = derr_q;
    lerr_d  = lerr_q;
    fbeat_d = fbeat_q;
    fdata_d = fdata_q;
    exp_d   = exp_q;
    pkt_d   = pkt_q;
    stall_d = stall_q;
    ncyc_d  = ncyc_q;
    thr_d   = thr_q;

    tready   = (state_q == ST_RUN) && (stall_q == '0);
    xfer     = axis.tvalid && tready;
    last_bad = axis.tlast != (pkt_q == 2'(PKT_BEATS - 1));

    // start wins over a coincident handshake: that beat is accepted and dropped
    if (start) begin
      beats_d = '0;
      derr_d  = '0;
      lerr_d  = '0;
      fbeat_d = '0;
      fdata_d = '0;
      exp_d   = '0;
      pkt_d   = '0;
      stall_d = '0;
      ncyc_d  = expected_cycles;
      thr_d   = throttle;
      state_d = (expected_cycles == '0) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (xfer) begin
        // counters saturate and never return to zero, so zero means no error yet
        if ((data_bad || last_bad) && derr_q == '0 && lerr_q == '0) begin
          fbeat_d = beats_q;
          fdata_d = axis.tdata[LANE_W-1:0];
        end
        if (data_bad) derr_d = sat_inc32(derr_q);
        if (last_bad) lerr_d = sat_inc32(lerr_q);
        beats_d = beats_q + 32'd1;
        exp_d   = exp_q + 16'd1;
        pkt_d   = pkt_q + 2'd1;
        stall_d = thr_q;
        if (beats_q + 32'd1 == ncyc_q) state_d = ST_DONE;
      end else if (stall_q != '0) begin
        stall_d = stall_q - 4'd1;
      end
    end

    axis.tready    = tready;
    beats_rcvd     = beats_q;
    data_errors    = derr_q;
    last_errors    = lerr_q;
    first_err_beat = fbeat_q;
    first_err_data = fdata_q;
    done           = (state_q == ST_DONE);
    pass           = (state_q == ST_DONE) && (derr_q == '0) && (lerr_q == '0);
  end

endmodule

// File: tb/tb_data_check.sv
// Self-checking bench for data_check: randomized pattern source with planted
// faults, checked against a beat-index reference model.
module tb_data_check;
  import data_check_pkg::*;

  localparam int unsigned DW    = 128;
  localparam int unsigned LANES = DW / 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] expected_cycles;
  logic [3:0]  throttle;
  logic [31:0] beats_rcvd, data_errors, last_errors, first_err_beat;
  logic [15:0] first_err_data;
  logic        done, pass;

  data_check_if #(.DW(DW)) axis ();

  data_check #(.DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .expected_cycles (expected_cycles),
    .throttle        (throttle),
    .axis            (axis),
    .beats_rcvd      (beats_rcvd),
    .data_errors     (data_errors),
    .last_errors     (last_errors),
    .first_err_beat  (first_err_beat),
    .first_err_data  (first_err_data),
    .done            (done),
    .pass            (pass)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // reference model: progress is just the count of accepted beats since start
  bit          m_run, m_done, m_err_seen;
  int unsigned m_gap, m_thr;
  logic [31:0] m_cycles, m_beats, m_derr, m_lerr, m_fbeat;
  logic [15:0] m_fdata;

  int unsigned src_n;
  int          mode;
  int unsigned vpct;
  bit          chk_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err_seen = 0; m_gap = 0; m_thr = 0;
    m_cycles = 0; m_beats = 0; m_derr = 0; m_lerr = 0; m_fbeat = 0; m_fdata = 0;
  endtask

  task automatic drive_beat();
    logic [DW-1:0] d;
    int unsigned   lane;
    for (int i = 0; i < int'(LANES); i++) d[i*16 +: 16] = src_n[15:0];
    axis.tlast  = (src_n % 4 == 3);
    axis.tvalid = ($urandom_range(99) < vpct);
    if (mode == 1) begin
      if (src_n == 4) d[5*16 +: 16] = 16'hBEEF;
      if (src_n == 7) axis.tlast = 1'b0;
    end else if (mode == 2) begin
      if ($urandom_range(19) == 0) begin
        lane = $urandom_range(LANES - 1);
        d[lane*16 +: 16] = d[lane*16 +: 16] ^ 16'($urandom_range(65535, 1));
      end
      if ($urandom_range(19) == 0) axis.tlast = ~axis.tlast;
    end
    axis.tdata = d;
  endtask

  task automatic step();
    bit rdy, xfer, dbad, lbad;
    @(negedge clk);
    rdy = m_run && (m_gap >= m_thr);
    if (chk_rdy) check("tready", axis.tready, rdy);
    xfer = rdy && axis.tvalid;
    if (start) begin
      m_beats = 0; m_derr = 0; m_lerr = 0; m_fbeat = 0; m_fdata = 0; m_err_seen = 0;
      m_cycles = expected_cycles; m_thr = throttle;
      m_run = (expected_cycles != 0); m_done = (expected_cycles == 0); m_gap = 16;
    end else if (xfer) begin
      dbad = 0;
      for (int i = 0; i < int'(LANES); i++)
        if (axis.tdata[i*16 +: 16] != m_beats[15:0]) dbad = 1;
      lbad = (axis.tlast != (m_beats % 4 == 3));
      if ((dbad || lbad) && !m_err_seen) begin
        m_err_seen = 1; m_fbeat = m_beats; m_fdata = axis.tdata[15:0];
      end
      if (dbad) m_derr = sat(m_derr);
      if (lbad) m_lerr = sat(m_lerr);
      m_beats = m_beats + 1;
      m_gap = 0;
      if (m_beats == m_cycles) begin m_run = 0; m_done = 1; end
    end else if (m_run && m_gap < 16) begin
      m_gap++;
    end
    if (start) src_n = 0;
    else if (xfer) src_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs();
    check("beats_rcvd", beats_rcvd, m_beats);
    check("data_errors", data_errors, m_derr);
    check("last_errors", last_errors, m_lerr);
    check("first_err_beat", first_err_beat, m_fbeat);
    check("first_err_data", first_err_data, m_fdata);
    check("done", done, m_done);
    check("pass", pass, m_done && m_derr == 0 && m_lerr == 0);
    check("tready_now", axis.tready, m_run && (m_gap >= m_thr));
  endtask

  task automatic run_test(input int unsigned ncyc, input int unsigned thr, input int unsigned vp,
                          input int md, input int unsigned restart_at, input bit chk,
                          output int unsigned done_cyc);
    int unsigned cyc, budget;
    bit          restarted;
    mode = md; vpct = vp; chk_rdy = chk;
    expected_cycles = ncyc; throttle = 4'(thr);
    start = 1; src_n = 0;
    drive_beat(); step(); start = 0;
    cyc = 0; done_cyc = 0; restarted = 0;
    budget = (ncyc + 8) * (thr + 1) * 4 + 100;
    while (!m_done && cyc < budget) begin
      if (restart_at != 0 && !restarted && src_n == restart_at) begin
        start = 1; restarted = 1;
      end
      drive_beat(); step(); start = 0; cyc++;
      if (done && done_cyc == 0) done_cyc = cyc;
    end
    check("in_budget", m_done, 1);
    axis.tvalid = 0;
    check_outputs();
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc;
    reset = 1; start = 0; expected_cycles = 0; throttle = 0;
    axis.tdata = '0; axis.tvalid = 0; axis.tlast = 0;
    mode = 0; vpct = 100; chk_rdy = 1; src_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_tready", axis.tready, 0);
    reset = 0;
    repeat (2) begin drive_beat(); step(); end

    // clean 8-beat run, no backpressure
    run_test(8, 0, 100, 0, 0, 1, dc);
    check("t1_beats", beats_rcvd, 8);
    check("t1_pass", pass, 1);
    check("t1_last_errors", last_errors, 0);

    // throttle 2: ready 1,0,0 repeated, 6 beats in 16 cycles
    run_test(6, 2, 100, 0, 0, 1, dc);
    check("t2_cycles", dc, 16);
    check("t2_pass", pass, 1);

    // lane 5 of beat 4 corrupted, tlast missing on beat 7
    run_test(10, 0, 100, 1, 0, 1, dc);
    check("t3_data_errors", data_errors, 1);
    check("t3_last_errors", last_errors, 1);
    check("t3_first_beat", first_err_beat, 4);
    check("t3_first_data", first_err_data, 16'h0004);
    check("t3_pass", pass, 0);

    // long run across the 16-bit counter wrap
    run_test(70000, 0, 100, 0, 0, 0, dc);
    check("t4_beats", beats_rcvd, 70000);
    check("t4_pass", pass, 1);

    // restart at beat 5 of a 20-beat run
    run_test(20, 0, 100, 0, 5, 1, dc);
    check("t5_beats", beats_rcvd, 20);
    check("t5_pass", pass, 1);

    // zero-length run
    mode = 0; vpct = 100; chk_rdy = 1;
    expected_cycles = 0; throttle = 0; start = 1; src_n = 0;
    drive_beat(); step(); start = 0;
    check("t6_done", done, 1);
    check("t6_pass", pass, 1);
    repeat (4) begin drive_beat(); step(); end
    check_outputs();

    // random traffic, throttle and faults
    for (int r = 0; r < 4; r++)
      run_test(20 + $urandom_range(20), $urandom_range(3), 50 + $urandom_range(50), 2, 0, 1, dc);

    // asynchronous reset mid-run
    mode = 0; vpct = 100; chk_rdy = 1;
    expected_cycles = 30; throttle = 0; start = 1; src_n = 0;
    drive_beat(); step(); start = 0;
    repeat (6) begin drive_beat(); step(); end
    check("t7_beats_pre", beats_rcvd, m_beats);
    #2 reset = 1;
    #1;
    check("t7_tready", axis.tready, 0);
    check("t7_done", done, 0);
    check("t7_beats", beats_rcvd, 0);
    check("t7_data_errors", data_errors, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    repeat (5) begin drive_beat(); step(); end
    check_outputs();
    run_test(12, 1, 80, 2, 0, 1, dc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
